pts_sequencer: RTL and testbench

//  Control FSM for the 32-point parallel-to-serial wrapper at the FFT output.
//  On each frame-ready pulse from the FFT core: one load_strobe to capture all NUM_POINTS bins,

---
 rtl/pts_pkg.sv | 10 +
 rtl/pts_beat_counter.sv | 37 +++
 rtl/pts_sequencer.sv | 97 +++++++++
 tb/tb_pts_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pts_pkg.sv
// Shared types and constants for the FFT-output parallel-to-serial sequencer.
package pts_pkg;
  localparam int PTS_NUM_POINTS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } pts_state_t;
endpackage

// File: rtl/pts_beat_counter.sv
// Bin index counter: cleared on frame load, advances per accepted beat, saturates at the last bin.
module pts_beat_counter #(
  parameter int NUM_POINTS = 32,
  parameter int IDX_W      = $clog2(NUM_POINTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [IDX_W-1:0] count,
  output logic             at_max
);

  logic [IDX_W-1:0] count_q, count_d;

  assign at_max = (count_q == IDX_W'(NUM_POINTS - 1));
  assign count  = count_q;

  // The only wrap back to 0 is a new frame load; SHIFT never overflows the index.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && !at_max) begin
      count_d = count_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/pts_sequencer.sv
// Control FSM for the PtS wrapper: one load strobe per frame, then one shift strobe per accepted bin,
// with a one-frame pending slot and a sticky overrun flag for frames that arrive with the slot full.
module pts_sequencer
  import pts_pkg::*;
#(
  parameter int NUM_POINTS = PTS_NUM_POINTS,
  parameter int IDX_W      = $clog2(NUM_POINTS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_ready,
  input  logic             sink_ready,
  input  logic             clear_overrun,
  output logic             load_strobe,
  output logic             out_strobe,
  output logic             sample_valid,
  output logic [IDX_W-1:0] sample_idx,
  output logic             sof,
  output logic             eof,
  output logic             busy,
  output logic             overrun
);

  pts_state_t       state_q, state_d;
  logic             pending_q, pending_d;
  logic             overrun_q, overrun_d;
  logic [IDX_W-1:0] idx;
  logic             idx_at_max;
  logic             last_beat;
  logic             overrun_set;

  pts_beat_counter #(
    .NUM_POINTS(NUM_POINTS),
    .IDX_W     (IDX_W)
  ) u_idx (
    .clk   (clk),
    .rst   (rst),
    .clear (load_strobe),
    .enable(out_strobe),
    .count (idx),
    .at_max(idx_at_max)
  );

  assign load_strobe  = (state_q == LOAD);
  assign sample_valid = (state_q == SHIFT);
  assign out_strobe   = sample_valid && sink_ready;
  assign sample_idx   = sample_valid ? idx : '0;
  assign sof          = sample_valid && (idx == '0);
  assign eof          = sample_valid && idx_at_max;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;

  assign last_beat   = out_strobe && idx_at_max;
  assign overrun_set = frame_ready && busy && pending_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (frame_ready) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (last_beat) state_d = (pending_q || frame_ready) ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A frame arriving on the last beat is launched directly, so it never occupies the slot.
  always_comb begin
    pending_d = pending_q;
    if (last_beat) begin
      pending_d = 1'b0;
    end else if (frame_ready && busy) begin
      pending_d = 1'b1;
    end
  end

  always_comb begin
    overrun_d = overrun_q;
    if (overrun_set) begin
      overrun_d = 1'b1;
    end else if (clear_overrun) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      overrun_q <= overrun_d;
    end
  end

endmodule

// File: tb/tb_pts_sequencer.sv
// Bench for pts_sequencer: vector table, directed frame schedules and random traffic against a beat-position model.
module tb_pts_sequencer;
  localparam int NP = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       frame_ready = 1'b0;
  logic       sink_ready = 1'b0;
  logic       clear_overrun = 1'b0;
  logic       load_strobe, out_strobe, sample_valid, sof, eof, busy, overrun;
  logic [4:0] sample_idx;

  pts_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .frame_ready  (frame_ready),
    .sink_ready   (sink_ready),
    .clear_overrun(clear_overrun),
    .load_strobe  (load_strobe),
    .out_strobe   (out_strobe),
    .sample_valid (sample_valid),
    .sample_idx   (sample_idx),
    .sof          (sof),
    .eof          (eof),
    .busy         (busy),
    .overrun      (overrun)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: m_beat = -2 idle, -1 load cycle, 0..NP-1 bin on the serial output.
  int m_beat;
  bit m_q;
  bit m_ovr;

  int cyc, n_load, n_out, first_load, sof_first, eof_first, eof_last;
  bit load_hist [0:255];
  bit busy_hist [0:255];
  bit ovr_hist  [0:255];

  typedef struct {
    logic       fr, sr, co;
    logic [11:0] exp;
  } vec_t;

  function automatic logic [11:0] pack_out();
    return {load_strobe, out_strobe, sample_valid, sample_idx, sof, eof, busy, overrun};
  endfunction

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_init();
    m_beat = -2; m_q = 0; m_ovr = 0;
    cyc = 0; n_load = 0; n_out = 0;
    first_load = -1; sof_first = -1; eof_first = -1; eof_last = -1;
  endtask

  task automatic do_reset();
    frame_ready = 0; sink_ready = 0; clear_overrun = 0;
    rst = 1;
    #1;
    tests++;
    if (pack_out() !== 12'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %h, expected 000", pack_out());
    end
    repeat (2) @(negedge clk);
    rst = 0;
    model_init();
  endtask

  // Called at a falling edge: drive, compare with model, advance the model, wait for next falling edge.
  task automatic step(input logic fr, input logic sr, input logic co);
    bit          vld, busy_m, last;
    logic [11:0] e, a;
    frame_ready = fr; sink_ready = sr; clear_overrun = co;
    #1;
    vld    = (m_beat >= 0);
    busy_m = (m_beat != -2);
    e = {m_beat == -1, vld && sr, vld, vld ? 5'(m_beat) : 5'd0,
         vld && m_beat == 0, vld && m_beat == NP - 1, busy_m, m_ovr};
    a = pack_out();
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL model_cycle %0d: got %h, expected %h (fr=%0b sr=%0b co=%0b)", cyc, a, e, fr, sr, co);
    end
    if (load_strobe) begin
      n_load++;
      if (first_load < 0) first_load = cyc;
    end
    if (out_strobe) n_out++;
    if (sof && sof_first < 0) sof_first = cyc;
    if (eof && out_strobe) begin
      if (eof_first < 0) eof_first = cyc;
      eof_last = cyc;
    end
    if (cyc < 256) begin
      load_hist[cyc] = load_strobe;
      busy_hist[cyc] = busy;
      ovr_hist[cyc]  = overrun;
    end
    last = vld && sr && (m_beat == NP - 1);
    if (fr && busy_m && m_q) m_ovr = 1;
    else if (co)             m_ovr = 0;
    if (last) begin
      m_beat = (m_q || fr) ? -1 : -2;
      m_q    = 0;
    end else begin
      if (fr && busy_m) m_q = 1;
      if (m_beat == -2)      m_beat = fr ? -1 : -2;
      else if (m_beat == -1) m_beat = 0;
      else if (sr)           m_beat = m_beat + 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  // Frame at cycle 5 plus optional extra frames, a sink stall window and a clear pulse.
  task automatic run_sched(input bit rst_first, input int ncyc, input int fa, input int fb,
                           input int st_from, input int st_len, input int co_at);
    if (rst_first) do_reset();
    for (int c = 0; c < ncyc; c++)
      step(c == 5 || c == fa || c == fb, !(c >= st_from && c < st_from + st_len), c == co_at);
  endtask

  vec_t vt [12];

  initial begin
    vt[0]  = '{0, 1, 0, 12'b0_0_0_00000_0_0_0_0};
    vt[1]  = '{1, 1, 0, 12'b0_0_0_00000_0_0_0_0};
    vt[2]  = '{0, 1, 0, 12'b1_0_0_00000_0_0_1_0};
    vt[3]  = '{0, 1, 0, 12'b0_1_1_00000_1_0_1_0};
    vt[4]  = '{0, 0, 0, 12'b0_0_1_00001_0_0_1_0};
    vt[5]  = '{0, 1, 0, 12'b0_1_1_00001_0_0_1_0};
    vt[6]  = '{0, 1, 0, 12'b0_1_1_00010_0_0_1_0};
    vt[7]  = '{1, 0, 0, 12'b0_0_1_00011_0_0_1_0};
    vt[8]  = '{1, 0, 0, 12'b0_0_1_00011_0_0_1_0};
    vt[9]  = '{0, 1, 0, 12'b0_1_1_00011_0_0_1_1};
    vt[10] = '{0, 1, 1, 12'b0_1_1_00100_0_0_1_1};
    vt[11] = '{0, 1, 0, 12'b0_1_1_00101_0_0_1_0};

    @(negedge clk);
    do_reset();
    for (int i = 0; i < 12; i++) begin
      frame_ready = vt[i].fr; sink_ready = vt[i].sr; clear_overrun = vt[i].co;
      #1;
      tests++;
      if (pack_out() !== vt[i].exp) begin
        fails++;
        $display("FAIL table_row %0d: got %b, expected %b", i, pack_out(), vt[i].exp);
      end
      @(negedge clk);
    end

    // Single frame, free-flowing sink.
    run_sched(1, 45, -1, -1, -1, 0, -1);
    check("single_load_cycle", first_load, 6);
    check("single_load_count", n_load, 1);
    check("single_sof_cycle", sof_first, 7);
    check("single_eof_cycle", eof_first, 38);
    check("single_beats", n_out, 32);
    check("single_busy_38", busy_hist[38], 1);
    check("single_idle_39", busy_hist[39], 0);

    // Sink stalls for 4 cycles while bin 3 is presented.
    run_sched(1, 50, -1, -1, 10, 4, -1);
    check("stall_eof_cycle", eof_first, 42);
    check("stall_beats", n_out, 32);

    // Second frame arrives at bin 10 and is queued.
    run_sched(1, 80, 17, -1, -1, 0, -1);
    check("b2b_load_39", load_hist[39], 1);
    check("b2b_loads", n_load, 2);
    check("b2b_beats", n_out, 64);
    check("b2b_eof2", eof_last, 71);
    check("b2b_no_overrun", ovr_hist[79], 0);

    // Second frame arrives exactly on the last beat.
    run_sched(1, 80, 38, -1, -1, 0, -1);
    check("edge_load_39", load_hist[39], 1);
    check("edge_loads", n_load, 2);
    check("edge_idle_72", busy_hist[72], 0);

    // Frames at bin 5 and bin 9: one queued, one dropped, then cleared.
    run_sched(1, 110, 12, 16, -1, 0, 60);
    check("ovr_before", ovr_hist[16], 0);
    check("ovr_set_bin10", ovr_hist[17], 1);
    check("ovr_held_at_clear", ovr_hist[60], 1);
    check("ovr_cleared", ovr_hist[61], 0);
    check("ovr_loads", n_load, 2);
    check("ovr_beats", n_out, 64);

    // Asynchronous reset while bin 17 is on the output.
    run_sched(1, 24, -1, -1, -1, 0, -1);
    frame_ready = 0; sink_ready = 1; clear_overrun = 0;
    #1;
    check("rst_pre_idx", sample_idx, 17);
    rst = 1;
    #1;
    check("rst_async_outputs", pack_out(), 0);
    @(negedge clk);
    rst = 0;
    model_init();
    run_sched(0, 45, -1, -1, -1, 0, -1);
    check("rst_restart_sof", sof_first, 7);
    check("rst_restart_beats", n_out, 32);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 699) == 0) do_reset();
      step($urandom_range(0, 14) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
